six_bit_serial_rx: RTL and testbench
====================================

Name: six_bit_serial_rx

Overview:
- Receiving end of the lab's 6-bit serial link. Watches a single-bit serial line, detects a start bit and shifts in 6 data bits MSB first.
- Checks the optional even-parity bit and the stop bit, then presents the assembled word on a parallel output with a valid/ack handshake.
- Sits downstream of a serial shift-register transmitter; one bit per clock, no oversampling.

Parameters:
- WIDTH, 6, number of data bits per frame (legal range 2..16).
- PARITY_EN, 1, 1 = frame carries an even-parity bit after the data; 0 = no parity bit.
- IDLE_LVL, 0, line level when idle and for the stop bit; start bit is ~IDLE_LVL.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- inp  input  1  serial line, sampled every rising clk edge.
- data_out  output  WIDTH  last correctly received word.
- valid  output  1  data_out holds an unconsumed word.
- ack  input  1  consumer takes data_out; honoured only when valid=1.
- busy  output  1  high while a frame is in progress (any state except IDLE).
- parity_err  output  1  one-cycle pulse: parity check failed; word discarded.
- frame_err  output  1  one-cycle pulse: stop bit not equal to IDLE_LVL; word discarded.
- overrun  output  1  one-cycle pulse: a good word arrived while valid=1 and ack=0; new word dropped.

Behaviour:
- Reset, sampled at the edge when rst=1:
  - state=IDLE, bit counter=0, shift register=0, data_out=0.
  - valid=0, busy=0, all error pulses=0.
  - rst overrides every other input, including mid-frame; the partial frame is discarded and no error is flagged.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: when inp=~IDLE_LVL, go to DATA and set count=0. Otherwise stay.
  - DATA: shift inp into the LSB of the shift register and increment count. After WIDTH samples, go to PARITY if PARITY_EN=1, else go to STOP.
  - PARITY: capture inp as the parity bit, then go to STOP.
  - STOP: sample inp and always return to IDLE. A new start bit can arrive on the very next cycle.
- Frame length is 1+WIDTH+PARITY_EN+1 clocks; the default is 9. Back-to-back frames are supported with no gap.
- Checks at the STOP sample:
  - Frame error: inp != IDLE_LVL. frame_err pulses on the next cycle.
  - Parity error: XOR of all data bits and the parity bit != 0. parity_err pulses on the next cycle.
  - If both errors occur, both flags pulse.
  - An erroneous word never reaches data_out.
- Good frame:
  - On the edge after the STOP sample, data_out is loaded and valid=1. Latency from stop-bit sample to valid is 1 clock.
  - The first received bit lands in data_out[WIDTH-1].
- Handshake:
  - With valid=1 and ack=1, valid drops on the next edge; data_out keeps its value.
  - ack while valid=0 is ignored.
- Simultaneous completion and ack (valid=1, ack=1 on the same edge a good word completes): new word loaded, valid stays 1, no overrun.
- Completion while valid=1 and ack=0: overrun pulses for 1 cycle, and data_out/valid are unchanged.
- busy is 1 in DATA, PARITY and STOP; 0 in IDLE.
- The counter uses clog2(WIDTH+1) bits and never wraps inside a frame.

Decomposition:
- Shared package `serial_link_pkg`:
  - state encoding constants (IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3);
  - default WIDTH=6;
  - IDLE_LVL default;
  - parity function (XOR reduce).
- The transmitter reuses the same package.
- Sub-module `sipo_shift_reg` (WIDTH-bit serial-in/parallel-out with shift enable and synchronous clear), instantiated once.
- FSM, checks and handshake stay in the top module.

Test Plan:
- Good frame: after reset, drive inp per cycle 1 (start), 1,0,1,1,0,0, 1 (parity), 0 (stop) → 1 cycle later valid=1, data_out=6'b101100, no error flags. Pulse ack → valid=0 next cycle, data_out still 6'b101100.
- Parity error: same frame with parity bit=0 → parity_err high for exactly 1 cycle, valid stays 0, data_out unchanged (0).
- Frame error: data 6'b111111, parity 0, stop bit 1 → frame_err 1-cycle pulse, no valid.
- Back-to-back and overrun:
  - Two consecutive good frames 6'b000001 then 6'b100000, with no ack → first word held and overrun pulses at end of second frame.
  - Repeat with ack asserted on second completion edge → data_out=6'b100000, valid=1, no overrun.
- Reset mid-frame: start + 3 data bits, rst=1 for 1 cycle → busy=0, valid=0, data_out=0. A following clean frame 6'b010101 (parity 1, stop 0) is received correctly.
- PARITY_EN=0 instance: 8-cycle frame 1, 0,1,1,0,1,0, 0 → data_out=6'b011010, valid=1.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared definitions for the 6-bit serial link: frame FSM states, defaults
// and the parity helper used by both the transmitter and the receiver.
package serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } link_state_e;

  localparam int   DEFAULT_WIDTH    = 6;
  localparam int   MAX_WIDTH        = 16;
  localparam logic DEFAULT_IDLE_LVL = 1'b0;

  // Reduction XOR; callers zero-extend narrower words to MAX_WIDTH.
  function automatic logic xor_reduce(input logic [MAX_WIDTH-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out shift register: shifts din into the LSB when
// shift_en is high, so the first bit shifted in ends up in the MSB.
module sipo_shift_reg #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  assign shift_d[0] = din;

  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_stage
    assign shift_d[gi] = shift_q[gi-1];
  end

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      shift_q <= '0;
    end else if (shift_en) begin
      shift_q <= shift_d;
    end
  end

  assign q = shift_q;

endmodule

// File: rtl/six_bit_serial_rx.sv
// Receiver for the serial link: start detect, MSB-first data capture,
// optional even-parity and stop-bit checks, and a valid/ack output register.
module six_bit_serial_rx
  import serial_link_pkg::*;
#(
  parameter int   WIDTH     = DEFAULT_WIDTH,
  parameter int   PARITY_EN = 1,
  parameter logic IDLE_LVL  = DEFAULT_IDLE_LVL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ack,
  output logic             busy,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  link_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic             shift_en;
  logic             shift_clr;
  logic [WIDTH-1:0] shift_word;
  logic [MAX_WIDTH-1:0] shift_ext;

  sipo_shift_reg #(
    .WIDTH (WIDTH)
  ) u_sipo (
    .clk      (clk),
    .srst     (rst),
    .clr      (shift_clr),
    .shift_en (shift_en),
    .din      (inp),
    .q        (shift_word)
  );

  always_comb begin
    shift_ext = '0;
    shift_ext[WIDTH-1:0] = shift_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    par_d     = par_q;
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    shift_en  = 1'b0;
    shift_clr = 1'b0;

    if (valid_q && ack) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (inp == ~IDLE_LVL) begin
          state_d   = DATA;
          cnt_d     = '0;
          par_d     = 1'b0;
          shift_clr = 1'b1;
        end
      end
      DATA: begin
        shift_en = 1'b1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        par_d   = inp;
        state_d = STOP;
      end
      STOP: begin
        state_d = IDLE;
        ferr_d  = (inp != IDLE_LVL);
        perr_d  = (PARITY_EN != 0) && (xor_reduce(shift_ext) ^ par_q);
        // A good word is only dropped if the previous one is still unconsumed.
        if (!ferr_d && !perr_d) begin
          if (!valid_q || ack) begin
            data_d  = shift_word;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign busy       = (state_q != IDLE);
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_six_bit_serial_rx.sv
// Scoreboard bench for six_bit_serial_rx: a default-parameter instance and a
// no-parity instance, driven one bit per clock.
module tb_six_bit_serial_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       inp, ack;
  logic [5:0] data_out;
  logic       valid, busy, parity_err, frame_err, overrun;

  logic       inp_np, ack_np;
  logic [5:0] data_out_np;
  logic       valid_np, busy_np, parity_err_np, frame_err_np, overrun_np;

  typedef struct {
    logic [5:0] data;
    logic       valid;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [5:0] data_m  = '0;
  logic       valid_m = 1'b0;

  always #5 clk = ~clk;

  six_bit_serial_rx dut (
    .clk        (clk),
    .rst        (rst),
    .inp        (inp),
    .data_out   (data_out),
    .valid      (valid),
    .ack        (ack),
    .busy       (busy),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  six_bit_serial_rx #(.PARITY_EN(0)) dut_np (
    .clk        (clk),
    .rst        (rst),
    .inp        (inp_np),
    .data_out   (data_out_np),
    .valid      (valid_np),
    .ack        (ack_np),
    .busy       (busy_np),
    .parity_err (parity_err_np),
    .frame_err  (frame_err_np),
    .overrun    (overrun_np)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one full frame; the model decides the outcome before the DUT sees it.
  task automatic send_frame(input logic [5:0] d, input logic p, input logic s,
                            input logic ack_end, input string tag);
    exp_t e;
    e.perr = ^{d, p};
    e.ferr = (s != 1'b0);
    e.ovr  = 1'b0;
    if (!e.perr && !e.ferr) begin
      if (!valid_m || ack_end) begin
        data_m  = d;
        valid_m = 1'b1;
      end else begin
        e.ovr = 1'b1;
      end
    end
    e.data  = data_m;
    e.valid = valid_m;
    exp_q.push_back(e);

    inp = 1'b1;
    tick();
    check_val({tag, ".busy_mid"}, 32'(busy), 32'd1);
    for (int i = 5; i >= 0; i--) begin
      inp = d[i];
      tick();
    end
    inp = p;
    tick();
    inp = s;
    ack = ack_end;
    tick();
    inp = 1'b0;
    ack = 1'b0;

    e = exp_q.pop_front();
    check_val({tag, ".data_out"},   32'(data_out),   32'(e.data));
    check_val({tag, ".valid"},      32'(valid),      32'(e.valid));
    check_val({tag, ".parity_err"}, 32'(parity_err), 32'(e.perr));
    check_val({tag, ".frame_err"},  32'(frame_err),  32'(e.ferr));
    check_val({tag, ".overrun"},    32'(overrun),    32'(e.ovr));
    check_val({tag, ".busy_end"},   32'(busy),       32'd0);
  endtask

  task automatic idle_check_pulses(input string tag);
    tick();
    check_val({tag, ".pulse_clear"}, 32'({parity_err, frame_err, overrun}), 32'd0);
    check_val({tag, ".valid_hold"},  32'(valid), 32'(valid_m));
  endtask

  task automatic pulse_ack(input string tag);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    valid_m = 1'b0;
    check_val({tag, ".valid"},    32'(valid),    32'd0);
    check_val({tag, ".data_out"}, 32'(data_out), 32'(data_m));
  endtask

  initial begin
    logic [7:0] np_bits;
    rst = 1'b1; inp = 1'b0; ack = 1'b0; inp_np = 1'b0; ack_np = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_val("reset.data_out", 32'(data_out), 32'd0);
    check_val("reset.valid",    32'(valid),    32'd0);
    check_val("reset.busy",     32'(busy),     32'd0);
    check_val("reset.flags",    32'({parity_err, frame_err, overrun}), 32'd0);
    check_val("reset.np_valid", 32'(valid_np), 32'd0);
    tick();

    send_frame(6'b101100, 1'b1, 1'b0, 1'b0, "good");
    idle_check_pulses("good");
    pulse_ack("good_ack");
    pulse_ack("stray_ack");

    send_frame(6'b101100, 1'b0, 1'b0, 1'b0, "perr");
    idle_check_pulses("perr");

    send_frame(6'b111111, 1'b0, 1'b1, 1'b0, "ferr");
    idle_check_pulses("ferr");

    send_frame(6'b000001, 1'b1, 1'b0, 1'b0, "b2b_1");
    send_frame(6'b100000, 1'b1, 1'b0, 1'b0, "b2b_ovr");
    idle_check_pulses("b2b_ovr");
    pulse_ack("b2b_ack");
    send_frame(6'b000001, 1'b1, 1'b0, 1'b0, "b2b_3");
    send_frame(6'b100000, 1'b1, 1'b0, 1'b1, "b2b_ackend");
    idle_check_pulses("b2b_ackend");

    // Abort a frame part-way with reset.
    inp = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      inp = i[0];
      tick();
    end
    rst = 1'b1;
    inp = 1'b0;
    tick();
    rst = 1'b0;
    data_m  = '0;
    valid_m = 1'b0;
    check_val("midrst.busy",     32'(busy),     32'd0);
    check_val("midrst.valid",    32'(valid),    32'd0);
    check_val("midrst.data_out", 32'(data_out), 32'd0);
    check_val("midrst.flags",    32'({parity_err, frame_err, overrun}), 32'd0);
    send_frame(6'b010101, 1'b1, 1'b0, 1'b0, "after_rst");

    // No-parity instance: 8-cycle frame.
    np_bits = 8'b1_011010_0;
    for (int i = 7; i >= 0; i--) begin
      inp_np = np_bits[i];
      tick();
    end
    inp_np = 1'b0;
    check_val("np.data_out", 32'(data_out_np), 32'h1a);
    check_val("np.valid",    32'(valid_np),    32'd1);
    check_val("np.flags",    32'({parity_err_np, frame_err_np, overrun_np}), 32'd0);
    check_val("np.busy",     32'(busy_np),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
